// File: rtl/reg_bank_reader_pkg.sv
// Shared constants for the register-bank reader: FSM encodings and stream direction.
package reg_bank_reader_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/reg_bank_reader_if.sv
// Command, bank and valid/ready stream signals between the reader and its consumer.
interface reg_bank_reader_if #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 4
);
  localparam int unsigned AW = (M > 1) ? $clog2(M) : 1;

  logic            start;
  logic            dir;
  logic [M*N-1:0]  bank_in;
  logic [N-1:0]    od;
  logic [AW-1:0]   oidx;
  logic            ov;
  logic            ordy;
  logic            busy;
  logic            done;

  // The reader is the stream source.
  modport master (
    input  start, dir, bank_in, ordy,
    output od, oidx, ov, busy, done
  );

  modport slave (
    output start, dir, bank_in, ordy,
    input  od, oidx, ov, busy, done
  );
endinterface

// File: rtl/reg_bank_reader_snapshot.sv
// M enabled N-bit registers sharing one load enable, with an index-selected read mux.
module bank_snapshot #(
  parameter int unsigned N  = 4,
  parameter int unsigned M  = 4,
  parameter int unsigned AW = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic [M*N-1:0] bank_i,
  input  logic [AW-1:0]  idx_i,
  output logic [N-1:0]   data_o
);

  logic [N-1:0] mem_q [M];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(M); k++) mem_q[k] <= '0;
    end else if (load_i) begin
      for (int k = 0; k < int'(M); k++) mem_q[k] <= bank_i[k*N +: N];
    end
  end

  assign data_o = mem_q[idx_i];

endmodule

// File: rtl/reg_bank_reader.sv
// Snapshots a packed register bank on start and streams its entries over valid/ready.
module reg_bank_reader
  import reg_bank_reader_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned M = 4
) (
  input  logic               clk,
  input  logic               rst,
  reg_bank_reader_if.master  bus
);

  localparam int unsigned AW      = (M > 1) ? $clog2(M) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(M - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          dir_q, dir_d;
  logic          load;
  logic          is_last;
  logic [N-1:0]  snap_data;

  bank_snapshot #(
    .N  (N),
    .M  (M),
    .AW (AW)
  ) u_snapshot (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (load),
    .bank_i (bus.bank_in),
    .idx_i  (idx_q),
    .data_o (snap_data)
  );

  assign is_last = (dir_q == DIR_DESC) ? (idx_q == '0) : (idx_q == LastIdx);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          dir_d   = bus.dir;
          idx_d   = (bus.dir == DIR_DESC) ? LastIdx : '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.ordy) begin
          if (is_last) begin
            state_d = ST_DONE;
          end else begin
            idx_d = (dir_q == DIR_DESC) ? idx_q - AW'(1) : idx_q + AW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dir_q   <= DIR_ASC;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
    end
  end

  // Outputs come straight from registered state, so ordy never reaches od combinationally.
  assign bus.od   = snap_data;
  assign bus.oidx = idx_q;
  assign bus.ov   = (state_q == ST_SEND);
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);

endmodule
